// File: rtl/uart_tx_param_if.sv
// Ready/valid word handshake between the system side and uart_tx_param.
// DW must match the transmitter's data_bits.
interface uart_tx_param_if #(parameter int DW = 8);
   logic          tx_valid;
   logic          tx_ready;
   logic [DW-1:0] tx_data;

   modport master (output tx_valid, output tx_data, input tx_ready);
   modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: data width, stop bits and bit order configurable.
// Optional parity bit when UART_TX_PARITY_EN is defined (parity_odd selects odd).
module uart_tx_param #(
   parameter int clk_freq   = 1000000,
   parameter int baud_rate  = 9600,
   parameter int data_bits  = 8,
   parameter int stop_bits  = 1,
   parameter int lsb_first  = 1,
   parameter int parity_odd = 0
) (
   input  logic            clk,
   input  logic            rst,
   uart_tx_param_if.slave  bus,
   output logic            tx,
   output logic            donetx,
   output logic            busy
);
   localparam int DIV = clk_freq / baud_rate;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
   localparam logic [3:0]    LAST_BIT  = 4'(data_bits - 1);
   localparam logic [3:0]    LAST_STOP = 4'(stop_bits - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd4;
   localparam logic       PAR_INV  = (parity_odd != 0);
`endif

   if (DIV < 2) begin : g_div_chk
      $error("uart_tx_param: clk_freq/baud_rate must be >= 2");
   end
   if (data_bits < 5 || data_bits > 9) begin : g_db_chk
      $error("uart_tx_param: data_bits must be 5..9");
   end
   if (stop_bits != 1 && stop_bits != 2) begin : g_sb_chk
      $error("uart_tx_param: stop_bits must be 1 or 2");
   end
   if (parity_odd != 0 && parity_odd != 1) begin : g_po_chk
      $error("uart_tx_param: parity_odd must be 0 or 1");
   end

   logic [2:0]           state;
   logic [CW-1:0]        baud_cnt;
   logic [3:0]           bit_cnt;
   logic [data_bits-1:0] shreg, shreg_nx;
   logic                 out_bit;
   logic                 baud_end;
`ifdef UART_TX_PARITY_EN
   logic                 par_bit;
`endif

   assign baud_end = (baud_cnt == BAUD_LAST);

   // Head of the shift register is the next line bit; shift direction follows bit order.
   always_comb begin
      if (lsb_first != 0) begin
         out_bit  = shreg[0];
         shreg_nx = shreg >> 1;
      end else begin
         out_bit  = shreg[data_bits-1];
         shreg_nx = shreg << 1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         baud_cnt     <= '0;
         bit_cnt      <= '0;
         shreg        <= '0;
         tx           <= 1'b1;
         bus.tx_ready <= 1'b1;
         donetx       <= 1'b0;
         busy         <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_bit      <= 1'b0;
`endif
      end else begin
         donetx <= 1'b0;
         if (state != S_IDLE)
            baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
         case (state)
            S_IDLE: begin
               if (bus.tx_valid && bus.tx_ready) begin
                  shreg        <= bus.tx_data;
`ifdef UART_TX_PARITY_EN
                  par_bit      <= (^bus.tx_data) ^ PAR_INV;
`endif
                  state        <= S_START;
                  baud_cnt     <= '0;
                  tx           <= 1'b0;
                  bus.tx_ready <= 1'b0;
                  busy         <= 1'b1;
               end
            end
            S_START: begin
               if (baud_end) begin
                  state   <= S_DATA;
                  bit_cnt <= '0;
                  tx      <= out_bit;
                  shreg   <= shreg_nx;
               end
            end
            S_DATA: begin
               if (baud_end) begin
                  if (bit_cnt == LAST_BIT) begin
                     bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                     state   <= S_PARITY;
                     tx      <= par_bit;
`else
                     state   <= S_STOP;
                     tx      <= 1'b1;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     tx      <= out_bit;
                     shreg   <= shreg_nx;
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (baud_end) begin
                  state <= S_STOP;
                  tx    <= 1'b1;
               end
            end
`endif
            // bit_cnt counts stop bits here so each one lasts a full DIV.
            S_STOP: begin
               if (baud_end) begin
                  if (bit_cnt == LAST_STOP) begin
                     state        <= S_IDLE;
                     bit_cnt      <= '0;
                     donetx       <= 1'b1;
                     bus.tx_ready <= 1'b1;
                     busy         <= 1'b0;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state        <= S_IDLE;
               baud_cnt     <= '0;
               bit_cnt      <= '0;
               tx           <= 1'b1;
               bus.tx_ready <= 1'b1;
               busy         <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter, the successor to the fixed 8N1 transmitter.
- Generalised in data width, stop-bit count and bit order; optional parity.
- Baud timing comes from a clock-enable counter in the `clk` domain, with no derived clock.
- Ready/valid byte handshake on the system side; serial `tx` line toward the pad.

Parameters:
- clk_freq, 1000000: system clock frequency in Hz.
- baud_rate, 9600: line bit rate in bits/s. The divisor is DIV = clk_freq/baud_rate, truncated. Elaboration fails if DIV < 2.
- data_bits, 8: data bits per frame, legal range 5..9.
- stop_bits, 1: stop bits per frame, 1 or 2. Any other value is an elaboration error.
- lsb_first, 1: 1 sends tx_data[0] first; 0 sends tx_data[data_bits-1] first.
- parity_odd, 0: used only when UART_TX_PARITY_EN is defined. 0 selects even parity, 1 selects odd parity.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- tx_valid  in  1  a frame word is offered.
- tx_ready  out  1  block can accept a word (registered).
- tx_data  in  data_bits  word to send; sampled only on acceptance.
- tx  out  1  serial line, idle high (registered).
- donetx  out  1  one-cycle pulse when a frame completes.
- busy  out  1  high from acceptance until frame end.

Behaviour:
- Reset (async, takes effect immediately, including mid-frame):
  - tx=1, tx_ready=1, donetx=0, busy=0.
  - State IDLE; baud counter and bit counter cleared.
  - An aborted frame never produces a donetx pulse.
- Acceptance occurs at a rising edge where tx_valid && tx_ready.
  - tx_data is latched into a shift register.
  - State becomes START; tx=0, tx_ready=0, busy=1 take effect after that same edge.
  - tx_valid while tx_ready=0 is ignored: no queuing, no error.
  - tx_data changes after acceptance have no effect.
- Bit timing:
  - The baud counter runs 0..DIV-1 only while not IDLE and restarts on every state/bit change.
  - Every line bit, including start, parity and each stop bit, is held exactly DIV clk cycles.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - START: tx=0 for DIV cycles, then DATA.
  - DATA: data_bits bits in the order set by lsb_first. The bit counter runs 0..data_bits-1. After the last bit, go to PARITY if enabled, otherwise STOP.
  - PARITY: one bit, then STOP.
  - STOP: tx=1 for stop_bits*DIV cycles.
  - At the edge ending STOP: state IDLE, donetx=1 for exactly one cycle, tx_ready=1, busy=0.
- Frame length, accept edge to donetx edge: (1 + data_bits + P + stop_bits)*DIV cycles, where P=1 with parity, else 0.
- Back-to-back frames:
  - With tx_valid held high, the next acceptance occurs one clk after donetx.
  - Minimum idle-high gap beyond the stop bits is therefore 1 clk.
- tx has no combinational path from inputs; tx_ready depends only on state.

Optional Feature:
UART_TX_PARITY_EN
- Defined:
  - PARITY state is present; P=1.
  - Parity bit = XOR of the latched data bits, inverted when parity_odd=1.
  - Computed from the latched word, not from live tx_data.
- Undefined:
  - No PARITY state and no parity logic; P=0.
  - parity_odd is ignored.

Test Plan:
All scenarios use clk_freq=1000000, baud_rate=100000 (DIV=10).
1. 8N1, lsb_first=1: accept 0xA5.
   - tx after acceptance: 0 for 10 clk, then 1,0,1,0,0,1,0,1 each 10 clk, then 1 for 10 clk.
   - donetx pulses exactly 100 clk after the accept edge; tx_ready=0 throughout, busy=1 throughout.
2. lsb_first=0, data_bits=7, stop_bits=2: accept 0x55.
   - Data bits on the line are 1,0,1,0,1,0,1 (MSB first).
   - Stop high for 20 clk; frame length 100 clk.
3. UART_TX_PARITY_EN defined, 8 data bits, 1 stop bit: accept 0xA5.
   - parity_odd=0: parity bit 0.
   - parity_odd=1: parity bit 1.
   - Frame length 110 clk in both cases.
4. Back-to-back: tx_valid held high, words 0x01 then 0xFF.
   - Second acceptance one clk after the first donetx.
   - tx high for 10+1 clk between the frames.
   - Changing tx_data mid-frame does not corrupt the first frame.
5. Assert rst for 3 clk at clk 45 of a frame.
   - tx=1, busy=0, tx_ready=1 immediately, before the next clk edge.
   - No donetx pulse appears.
   - A new word accepted after reset is sent correctly.
6. tx_valid pulsed while busy=1: no acceptance, current frame unchanged, donetx count unchanged.
